// File: rtl/csa_pkg.sv
// Shared sizing helpers for the CSA multi-operand adder: tree depth, output
// width and pipeline stage count as constant functions.
package csa_pkg;

  // Rows left after `lvl` levels of 3:2 reduction starting from n rows.
  function automatic int rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < 64; i++) begin
      if ((i < lvl) && (r > 2)) begin
        r = 2 * (r / 3) + (r % 3);
      end
    end
    return r;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (r > 2) begin
        r = 2 * (r / 3) + (r % 3);
        l = l + 1;
      end
    end
    return l;
  endfunction

  function automatic int out_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

  function automatic int stage_count(input int n, input int pipe);
    return (csa_levels(n) + pipe - 1) / pipe;
  endfunction

  localparam int OW = out_width(25, 16);
  localparam int AW = OW;

endpackage

// File: rtl/csa_3to2_row.sv
// One row of WR full adders; carry row is pre-shifted so sum + carry equals
// a + b + c modulo 2^WR.
module csa_3to2_row #(
  parameter int WR = 8
) (
  input  logic [WR-1:0] a_i,
  input  logic [WR-1:0] b_i,
  input  logic [WR-1:0] c_i,
  output logic [WR-1:0] sum_o,
  output logic [WR-1:0] carry_o
);
  logic [WR-1:0] maj_s;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj_s   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = maj_s << 1;
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined N-operand adder: 3:2 CSA tree with stage registers every PIPE
// levels, a registered final adder and optional accumulation across beats.
module csa_tree_pipe
  import csa_pkg::*;
#(
  parameter int N        = 25,
  parameter int W        = 16,
  parameter int SIGNED   = 0,
  parameter int PIPE     = 2,
  parameter int ACC_EN   = 0,
  parameter int ACC_BITS = 4,
  localparam int OWL = out_width(N, W),
  localparam int AWL = OWL + ((ACC_EN != 0) ? ACC_BITS : 0)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AWL-1:0] out_data
);
  localparam int L = csa_levels(N);

  logic [OWL-1:0] row_s [0:L][0:N-1];
  logic           vld_s [0:L];
  logic           lst_s [0:L];
  logic           en_s;
  logic [OWL-1:0] tree_sum_s;
  logic [AWL-1:0] tree_ext_s;
  logic [AWL-1:0] acc_sum_s;
  logic [AWL-1:0] acc_q;
  logic [AWL-1:0] out_data_q;
  logic           out_valid_q;

  // Global stall: the whole pipe freezes while a result waits downstream.
  assign en_s     = !out_valid_q || out_ready;
  assign in_ready = en_s;
  assign vld_s[0] = in_valid;
  assign lst_s[0] = in_last;

  for (genvar k = 0; k < N; k++) begin : g_ext
    if (SIGNED != 0) begin : g_s
      assign row_s[0][k] = {{(OWL-W){in_data[k*W+W-1]}}, in_data[k*W +: W]};
    end else begin : g_u
      assign row_s[0][k] = {{(OWL-W){1'b0}}, in_data[k*W +: W]};
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int RI = rows_at(N, l);
    localparam int RO = rows_at(N, l + 1);
    localparam int G  = RI / 3;
    logic [OWL-1:0] nx_s [0:N-1];

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2_row #(.WR(OWL)) u_row (
        .a_i    (row_s[l][3*g]),
        .b_i    (row_s[l][3*g+1]),
        .c_i    (row_s[l][3*g+2]),
        .sum_o  (nx_s[2*g]),
        .carry_o(nx_s[2*g+1])
      );
    end
    for (genvar j = 0; j < RI - 3*G; j++) begin : g_pass
      assign nx_s[2*G+j] = row_s[l][3*G+j];
    end
    for (genvar j = RO; j < N; j++) begin : g_zero
      assign nx_s[j] = '0;
    end

    if ((((l + 1) % PIPE) == 0) || ((l + 1) == L)) begin : g_reg
      logic [OWL-1:0] row_q [0:N-1];
      logic           vld_q;
      logic           lst_q;

      // Stage register after this level; holds on stall.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < N; j++) row_q[j] <= '0;
          vld_q <= 1'b0;
          lst_q <= 1'b0;
        end else if (en_s) begin
          for (int j = 0; j < N; j++) row_q[j] <= nx_s[j];
          vld_q <= vld_s[l];
          lst_q <= lst_s[l];
        end
      end
      for (genvar j = 0; j < N; j++) begin : g_out
        assign row_s[l+1][j] = row_q[j];
      end
      assign vld_s[l+1] = vld_q;
      assign lst_s[l+1] = lst_q;
    end else begin : g_comb
      for (genvar j = 0; j < N; j++) begin : g_out
        assign row_s[l+1][j] = nx_s[j];
      end
      assign vld_s[l+1] = vld_s[l];
      assign lst_s[l+1] = lst_s[l];
    end
  end

  assign tree_sum_s = row_s[L][0] + row_s[L][1];

  if (AWL == OWL) begin : g_noext
    assign tree_ext_s = tree_sum_s;
  end else if (SIGNED != 0) begin : g_sext
    assign tree_ext_s = {{(AWL-OWL){tree_sum_s[OWL-1]}}, tree_sum_s};
  end else begin : g_zext
    assign tree_ext_s = {{(AWL-OWL){1'b0}}, tree_sum_s};
  end

  assign acc_sum_s = acc_q + tree_ext_s;

  // Final adder register; the accumulator restarts at zero on a last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
    end else if (en_s) begin
      out_valid_q <= vld_s[L] && ((ACC_EN == 0) || lst_s[L]);
      if (vld_s[L]) begin
        if (ACC_EN == 0) begin
          out_data_q <= tree_ext_s;
        end else if (lst_s[L]) begin
          out_data_q <= acc_sum_s;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_sum_s;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed bench for csa_tree_pipe: four configurations, a queue-based sum
// model for the main instance, and literal expectations from hand arithmetic.
module tb_csa_tree_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // A: N=25 W=16 unsigned PIPE=2 (LAT=5)
  logic a_valid, a_ready, a_last, a_ovalid, a_oready;
  logic [399:0] a_data;
  logic [20:0]  a_odata;
  // B: N=9 W=8 signed PIPE=3
  logic b_valid, b_ready, b_last, b_ovalid, b_oready;
  logic [71:0] b_data;
  logic [11:0] b_odata;
  // C: N=25 W=16 accumulate, AW=25
  logic c_valid, c_ready, c_last, c_ovalid, c_oready;
  logic [399:0] c_data;
  logic [24:0]  c_odata;
  // D: N=2 W=8 PIPE=1 (no tree levels, LAT=1)
  logic d_valid, d_ready, d_last, d_ovalid, d_oready;
  logic [15:0] d_data;
  logic [8:0]  d_odata;

  csa_tree_pipe #(.N(25), .W(16), .SIGNED(0), .PIPE(2), .ACC_EN(0), .ACC_BITS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_last(a_last), .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata));
  csa_tree_pipe #(.N(9), .W(8), .SIGNED(1), .PIPE(3), .ACC_EN(0), .ACC_BITS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata));
  csa_tree_pipe #(.N(25), .W(16), .SIGNED(0), .PIPE(2), .ACC_EN(1), .ACC_BITS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
    .in_last(c_last), .out_valid(c_ovalid), .out_ready(c_oready), .out_data(c_odata));
  csa_tree_pipe #(.N(2), .W(8), .SIGNED(0), .PIPE(1), .ACC_EN(0), .ACC_BITS(4)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(d_ready), .in_data(d_data),
    .in_last(d_last), .out_valid(d_ovalid), .out_ready(d_oready), .out_data(d_odata));

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: plain integer sum of the 25 operands, wrapped to 21 bits.
  function automatic logic [20:0] mdl_a(input logic [399:0] d);
    longint s;
    logic [63:0] sv;
    s = 0;
    for (int k = 0; k < 25; k++) s += longint'(d[k*16 +: 16]);
    sv = 64'(s);
    return sv[20:0];
  endfunction

  task automatic rand_a();
    for (int k = 0; k < 25; k++) a_data[k*16 +: 16] = 16'($urandom);
  endtask

  // Scoreboard for instance A: order, value, stall stability and latency.
  logic [20:0] exp_q[$];
  int          acc_cyc_q[$];
  logic        hold_vld;
  logic [20:0] hold_data;
  bit          lat_chk = 1'b0;
  int          n_pop = 0;
  int          pop_cyc;
  logic [20:0] pop_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (a_ovalid && hold_vld) chk("a_hold", a_odata, hold_data);
      if (a_ovalid && a_oready) begin
        chk("a_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          pop_val = exp_q.pop_front();
          pop_cyc = acc_cyc_q.pop_front();
          chk("a_sum", a_odata, pop_val);
          if (lat_chk) chk("a_lat", cyc - pop_cyc, 5);
          n_pop++;
        end
      end
      hold_vld  = a_ovalid && !a_oready;
      hold_data = a_odata;
      if (a_valid && a_ready) begin
        exp_q.push_back(mdl_a(a_data));
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  logic [11:0] b_got[$];
  logic [24:0] c_got[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_ovalid && b_oready) b_got.push_back(b_odata);
      if (c_ovalid && c_oready) c_got.push_back(c_odata);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int  t0;
    bit  got;
    int  sent;
    bit  prev_acc;
    int  pop0;
    logic [399:0] all_ff;

    rst_n = 1'b0;
    {a_valid, b_valid, c_valid, d_valid} = 4'b0;
    {a_last, b_last, c_last, d_last}     = 4'b0;
    {a_oready, b_oready, c_oready, d_oready} = 4'b1111;
    a_data = '0; b_data = '0; c_data = '0; d_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ovalid", a_ovalid, 1'b0);
    chk("rst_a_odata", a_odata, 21'h0);
    chk("rst_c_odata", c_odata, 25'h0);
    chk("rst_d_ovalid", d_ovalid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_c_ready", c_ready, 1'b1);

    // Model pin and single-beat latency on A.
    for (int k = 0; k < 25; k++) all_ff[k*16 +: 16] = 16'hFFFF;
    chk("model_pin_ffff", mdl_a(all_ff), 21'h18FFE7);
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = all_ff;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    a_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_ovalid) got = 1'b1;
    end
    chk("a_lat_seen", got, 1'b1);
    chk("a_lat_cycles", cyc - t0, 5);
    chk("a_ffff_sum", a_odata, 21'h18FFE7);

    // Signed N=9: all 0x80 then alternating 0x7F/0x81.
    @(posedge clk); #1;
    b_valid = 1'b1;
    for (int k = 0; k < 9; k++) b_data[k*8 +: 8] = 8'h80;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) b_data[k*8 +: 8] = (k % 2 == 0) ? 8'h7F : 8'h81;
    @(posedge clk); #1;
    b_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b_count", b_got.size(), 2);
    chk("b_all80", (b_got.size() > 0) ? b_got[0] : 12'hxxx, 12'hB80);
    chk("b_alt7f81", (b_got.size() > 1) ? b_got[1] : 12'hxxx, 12'h07F);

    // N=2 boundary: one-cycle latency, back-to-back.
    @(posedge clk); #1;
    d_valid = 1'b1;
    d_data  = {8'hFF, 8'hFF};
    @(negedge clk);
    @(posedge clk); #1;
    d_data = {8'h02, 8'h01};
    @(negedge clk);
    chk("d_v1", d_ovalid, 1'b1);
    chk("d_sum1", d_odata, 9'h1FE);
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(negedge clk);
    chk("d_v2", d_ovalid, 1'b1);
    chk("d_sum2", d_odata, 9'h003);
    @(negedge clk);
    chk("d_idle", d_ovalid, 1'b0);

    // Accumulation: 1,1,1(last) then 2(last), all back-to-back.
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      c_valid = 1'b1;
      c_last  = (b >= 2);
      for (int k = 0; k < 25; k++) c_data[k*16 +: 16] = (b == 3) ? 16'h0002 : 16'h0001;
    end
    @(posedge clk); #1;
    c_valid = 1'b0;
    c_last  = 1'b0;
    repeat (10) @(negedge clk);
    chk("c_count", c_got.size(), 2);
    chk("c_grp75", (c_got.size() > 0) ? c_got[0] : 25'hxxxxxxx, 25'd75);
    chk("c_grp50", (c_got.size() > 1) ? c_got[1] : 25'hxxxxxxx, 25'd50);

    // Streaming: 100 random beats with the sink always ready.
    pop0    = n_pop;
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      a_valid = 1'b1;
      rand_a();
      @(negedge clk);
      chk("a_stream_ready", a_ready, 1'b1);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (8) @(negedge clk);
    lat_chk = 1'b0;
    chk("a_stream_count", n_pop - pop0, 100);

    // Backpressure: sink stalls, then toggles, while 16 beats are pushed.
    pop0     = n_pop;
    sent     = 0;
    prev_acc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      a_oready = (i < 10) ? 1'b0 : (i % 3 != 0);
      if (prev_acc) begin
        if (sent < 16) begin
          a_valid = 1'b1;
          rand_a();
          sent++;
        end else begin
          a_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (!a_oready) chk("a_stall_ready", a_ready, !a_ovalid);
      prev_acc = !a_valid || a_ready;
    end
    @(posedge clk); #1;
    a_oready = 1'b1;
    a_valid  = 1'b0;
    repeat (10) @(negedge clk);
    chk("a_bp_count", n_pop - pop0, 16);
    chk("a_bp_drain", exp_q.size(), 0);

    // Reset with A beats in flight and a partial accumulation in C.
    c_got.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a_valid = 1'b1;
      rand_a();
      c_valid = (i < 2);
      c_last  = 1'b0;
      for (int k = 0; k < 25; k++) c_data[k*16 +: 16] = 16'h0001;
    end
    @(posedge clk); #2;
    a_valid = 1'b0;
    c_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst_mid_a_ovalid", a_ovalid, 1'b0);
    chk("rst_mid_a_odata", a_odata, 21'h0);
    chk("rst_mid_c_ovalid", c_ovalid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b1;
    rand_a();
    c_valid = 1'b1;
    c_last  = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    c_valid = 1'b0;
    c_last  = 1'b0;
    repeat (10) @(negedge clk);
    chk("c_after_rst_count", c_got.size(), 1);
    chk("c_after_rst_sum", (c_got.size() > 0) ? c_got[0] : 25'hxxxxxxx, 25'd25);
    chk("a_after_rst_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
